camera_cfg_bank: RTL

Multi-channel configuration and status register bank for the uDMA parallel camera interface. It serves N_CH independent RX channels and one shared set of camera window/filter registers. Window registers are double-buffered: writes land in a shadow copy and reach the active copy only on a frame boundary, so a new configuration never takes effect mid-frame. The bank also owns sticky interrupt status with write-1-to-clear and a single level interrupt output. It sits between the peripheral config bus and the camera datapath and channel uDMA logic.

---
 rtl/camera_cfg_pkg.sv | 55 +++++
 rtl/camera_irq_ctrl.sv | 44 ++++
 rtl/camera_cfg_bank.sv | 257 +++++++++++++++++++++++++
 3 files changed

// File: rtl/camera_cfg_pkg.sv
// Shared constants for the camera config bank: register map, channel
// register offsets, CFG bit layout, shadow control bits and IRQ bit layout.
package camera_cfg_pkg;

   // Per-channel word offsets inside the 4-word channel window.
   localparam logic [1:0] CH_SADDR = 2'd0;
   localparam logic [1:0] CH_SIZE  = 2'd1;
   localparam logic [1:0] CH_CFG   = 2'd2;

   // Channel CFG register bit positions.
   localparam int CFG_CONT   = 0;
   localparam int CFG_DSIZE  = 1;   // two bits wide
   localparam int CFG_FILTER = 3;
   localparam int CFG_EN     = 4;
   localparam int CFG_CLR    = 5;

   // Global register word addresses.
   localparam logic [5:0] ADDR_GLOB        = 6'h20;
   localparam logic [5:0] ADDR_LL          = 6'h21;
   localparam logic [5:0] ADDR_UR          = 6'h22;
   localparam logic [5:0] ADDR_SIZE        = 6'h23;
   localparam logic [5:0] ADDR_FILTER      = 6'h24;
   localparam logic [5:0] ADDR_SHADOW_CTRL = 6'h25;
   localparam logic [5:0] ADDR_IRQ_EN      = 6'h26;
   localparam logic [5:0] ADDR_IRQ_STATUS  = 6'h27;

   // Double-buffered window registers, indexed by (addr - ADDR_GLOB).
   localparam int NUM_WIN    = 5;
   localparam int WIN_GLOB   = 0;
   localparam int WIN_LL     = 1;
   localparam int WIN_UR     = 2;
   localparam int WIN_SIZE   = 3;
   localparam int WIN_FILTER = 4;

   // SHADOW_CTRL bits.
   localparam int SC_COMMIT = 0;
   localparam int SC_BYPASS = 1;

   // IRQ status/enable bit layout.
   localparam int IRQ_EOT_BASE  = 0;
   localparam int IRQ_FRAME_END = 8;
   localparam int IRQ_OVF       = 9;
   localparam int IRQ_NUM_EV    = 10;

   // Bits that physically exist for a given channel count; the rest read 0.
   function automatic logic [IRQ_NUM_EV-1:0] irq_valid_mask(input int n_ch);
      logic [IRQ_NUM_EV-1:0] m;
      m = '0;
      for (int i = 0; i < n_ch; i++) m[IRQ_EOT_BASE+i] = 1'b1;
      m[IRQ_FRAME_END] = 1'b1;
      m[IRQ_OVF]       = 1'b1;
      return m;
   endfunction

endpackage

// File: rtl/camera_irq_ctrl.sv
// Sticky interrupt status with write-1-to-clear, an enable register and a
// level interrupt derived from the registered status.
module camera_irq_ctrl #(
   parameter int              N_EV    = 10,
   parameter logic [N_EV-1:0] EV_MASK = '1
) (
   input  logic            clk_i,
   input  logic            rst_i,
   input  logic [N_EV-1:0] ev_i,
   input  logic            en_we_i,
   input  logic            clr_we_i,
   input  logic [N_EV-1:0] wdata_i,
   output logic [N_EV-1:0] en_o,
   output logic [N_EV-1:0] status_o,
   output logic            irq_o
);

   logic [N_EV-1:0] status_q, status_d;
   logic [N_EV-1:0] en_q, en_d;
   logic [N_EV-1:0] clr_mask;

   // Clear first, then OR in events so a same-cycle event wins over W1C.
   always_comb begin
      clr_mask = clr_we_i ? wdata_i : '0;
      status_d = ((status_q & ~clr_mask) | ev_i) & EV_MASK;
      en_d     = en_we_i ? (wdata_i & EV_MASK) : en_q;
   end

   // Status and enable state.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         status_q <= '0;
         en_q     <= '0;
      end else begin
         status_q <= status_d;
         en_q     <= en_d;
      end
   end

   assign en_o     = en_q;
   assign status_o = status_q;
   assign irq_o    = |(status_q & en_q);

endmodule

// File: rtl/camera_cfg_bank.sv
// Config/status register bank for the parallel camera uDMA: per-channel RX
// registers, double-buffered camera window registers committed on frame start,
// and sticky interrupt status.
module camera_cfg_bank
   import camera_cfg_pkg::*;
#(
   parameter int N_CH           = 2,
   parameter int L2_AWIDTH_NOAL = 12,
   parameter int TRANS_SIZE     = 16
) (
   input  logic                           clk_i,
   input  logic                           rst_i,
   input  logic [31:0]                    cfg_data_i,
   input  logic [5:0]                     cfg_addr_i,
   input  logic                           cfg_valid_i,
   input  logic                           cfg_rwn_i,
   output logic [31:0]                    cfg_data_o,
   output logic                           cfg_ready_o,
   output logic [N_CH*L2_AWIDTH_NOAL-1:0] cfg_rx_startaddr_o,
   output logic [N_CH*TRANS_SIZE-1:0]     cfg_rx_size_o,
   output logic [2*N_CH-1:0]              cfg_rx_datasize_o,
   output logic [N_CH-1:0]                cfg_rx_continuous_o,
   output logic [N_CH-1:0]                cfg_rx_filter_o,
   output logic [N_CH-1:0]                cfg_rx_en_o,
   output logic [N_CH-1:0]                cfg_rx_clr_o,
   input  logic [N_CH-1:0]                cfg_rx_en_i,
   input  logic [N_CH-1:0]                cfg_rx_pending_i,
   input  logic [N_CH*L2_AWIDTH_NOAL-1:0] cfg_rx_curr_addr_i,
   input  logic [N_CH*TRANS_SIZE-1:0]     cfg_rx_bytes_left_i,
   input  logic [N_CH-1:0]                cfg_rx_eot_i,
   input  logic                           frame_start_i,
   input  logic                           frame_end_i,
   input  logic                           overflow_i,
   input  logic                           cfg_cam_ip_en_i,
   output logic [31:0]                    cfg_cam_cfg_o,
   output logic [31:0]                    cfg_cam_cfg_ll_o,
   output logic [31:0]                    cfg_cam_cfg_ur_o,
   output logic [31:0]                    cfg_cam_cfg_size_o,
   output logic [31:0]                    cfg_cam_cfg_filter_o,
   output logic                           cfg_update_o,
   output logic                           irq_o
);

   localparam int AW = L2_AWIDTH_NOAL;
   localparam int TS = TRANS_SIZE;
   localparam logic [IRQ_NUM_EV-1:0] IRQ_MASK = irq_valid_mask(N_CH);

   // ---------------- address decode ----------------
   logic       wr;
   logic [2:0] ch_idx;
   logic [1:0] ch_reg;
   logic       ch_hit;
   logic [2:0] win_idx;
   logic       win_hit;

   assign wr      = cfg_valid_i & ~cfg_rwn_i;
   assign ch_idx  = cfg_addr_i[4:2];
   assign ch_reg  = cfg_addr_i[1:0];
   assign ch_hit  = ~cfg_addr_i[5] & (int'(ch_idx) < N_CH);
   assign win_idx = cfg_addr_i[2:0];
   assign win_hit = (cfg_addr_i[5:3] == 3'b100) & (int'(win_idx) < NUM_WIN);

   // ---------------- per-channel registers ----------------
   logic [N_CH-1:0][AW-1:0] saddr_q, saddr_d;
   logic [N_CH-1:0][TS-1:0] size_q, size_d;
   logic [N_CH-1:0][1:0]    dsize_q, dsize_d;
   logic [N_CH-1:0]         cont_q, cont_d;
   logic [N_CH-1:0]         filt_q, filt_d;
   logic [N_CH-1:0]         en_p_q, en_p_d;
   logic [N_CH-1:0]         clr_p_q, clr_p_d;
   logic [N_CH-1:0][AW-1:0] curr_addr;
   logic [N_CH-1:0][TS-1:0] bytes_left;

   assign curr_addr  = cfg_rx_curr_addr_i;
   assign bytes_left = cfg_rx_bytes_left_i;

   // Channel register writes; en/clr are self-clearing one-cycle strobes.
   always_comb begin
      saddr_d = saddr_q;
      size_d  = size_q;
      dsize_d = dsize_q;
      cont_d  = cont_q;
      filt_d  = filt_q;
      en_p_d  = '0;
      clr_p_d = '0;
      for (int c = 0; c < N_CH; c++) begin
         if (wr && ch_hit && int'(ch_idx) == c) begin
            case (ch_reg)
               CH_SADDR: saddr_d[c] = cfg_data_i[AW-1:0];
               CH_SIZE:  size_d[c]  = cfg_data_i[TS-1:0];
               CH_CFG: begin
                  cont_d[c]  = cfg_data_i[CFG_CONT];
                  dsize_d[c] = cfg_data_i[CFG_DSIZE +: 2];
                  filt_d[c]  = cfg_data_i[CFG_FILTER];
                  en_p_d[c]  = cfg_data_i[CFG_EN];
                  clr_p_d[c] = cfg_data_i[CFG_CLR];
               end
               default: ;
            endcase
         end
      end
   end

   // Channel register state.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         saddr_q <= '0;
         size_q  <= '0;
         dsize_q <= '0;
         cont_q  <= '0;
         filt_q  <= '0;
         en_p_q  <= '0;
         clr_p_q <= '0;
      end else begin
         saddr_q <= saddr_d;
         size_q  <= size_d;
         dsize_q <= dsize_d;
         cont_q  <= cont_d;
         filt_q  <= filt_d;
         en_p_q  <= en_p_d;
         clr_p_q <= clr_p_d;
      end
   end

   // ---------------- double-buffered window registers ----------------
   logic [NUM_WIN-1:0][31:0] shadow_q, shadow_d;
   logic [NUM_WIN-1:0][31:0] active_q, active_d;
   logic pending_q, pending_d;
   logic bypass_q, bypass_d;
   logic update_q, update_d;
   logic copy, commit;

   assign copy   = frame_start_i & pending_q;
   assign commit = wr & (cfg_addr_i == ADDR_SHADOW_CTRL) & cfg_data_i[SC_COMMIT];

   // Frame-boundary copy uses the pre-write shadow; a bypass write then
   // overrides its own register in the active copy.
   always_comb begin
      shadow_d = shadow_q;
      active_d = active_q;
      bypass_d = bypass_q;
      update_d = 1'b0;
      if (copy) begin
         active_d = shadow_q;
         update_d = 1'b1;
      end
      for (int w = 0; w < NUM_WIN; w++) begin
         if (wr && win_hit && int'(win_idx) == w) begin
            shadow_d[w] = cfg_data_i;
            if (bypass_q) begin
               active_d[w] = cfg_data_i;
               update_d    = 1'b1;
            end
         end
      end
      if (wr && cfg_addr_i == ADDR_SHADOW_CTRL) bypass_d = cfg_data_i[SC_BYPASS];
      // A commit only arms an idle bank; an armed bank clears on its copy.
      pending_d = pending_q ? ~copy : commit;
   end

   // Window register state.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         shadow_q  <= '0;
         active_q  <= '0;
         pending_q <= 1'b0;
         bypass_q  <= 1'b0;
         update_q  <= 1'b0;
      end else begin
         shadow_q  <= shadow_d;
         active_q  <= active_d;
         pending_q <= pending_d;
         bypass_q  <= bypass_d;
         update_q  <= update_d;
      end
   end

   // ---------------- interrupts ----------------
   logic [IRQ_NUM_EV-1:0] irq_ev, irq_en, irq_status;

   // Gather event pulses into the status bit layout.
   always_comb begin
      irq_ev                           = '0;
      irq_ev[IRQ_EOT_BASE +: N_CH]     = cfg_rx_eot_i;
      irq_ev[IRQ_FRAME_END]            = frame_end_i;
      irq_ev[IRQ_OVF]                  = overflow_i;
   end

   camera_irq_ctrl #(
      .N_EV    (IRQ_NUM_EV),
      .EV_MASK (IRQ_MASK)
   ) u_irq (
      .clk_i    (clk_i),
      .rst_i    (rst_i),
      .ev_i     (irq_ev),
      .en_we_i  (wr && cfg_addr_i == ADDR_IRQ_EN),
      .clr_we_i (wr && cfg_addr_i == ADDR_IRQ_STATUS),
      .wdata_i  (cfg_data_i[IRQ_NUM_EV-1:0]),
      .en_o     (irq_en),
      .status_o (irq_status),
      .irq_o    (irq_o)
   );

   // ---------------- read mux ----------------
   logic [31:0] rdata;

   // Combinational read; everything unmapped or unimplemented reads 0.
   always_comb begin
      rdata = '0;
      if (ch_hit) begin
         for (int c = 0; c < N_CH; c++) begin
            if (int'(ch_idx) == c) begin
               case (ch_reg)
                  CH_SADDR: rdata[AW-1:0] = curr_addr[c];
                  CH_SIZE:  rdata[TS-1:0] = bytes_left[c];
                  CH_CFG:   rdata[CFG_CLR:0] = {cfg_rx_pending_i[c], cfg_rx_en_i[c],
                                                filt_q[c], dsize_q[c], cont_q[c]};
                  default: ;
               endcase
            end
         end
      end else if (win_hit) begin
         for (int w = 0; w < NUM_WIN; w++) begin
            if (int'(win_idx) == w) rdata = shadow_q[w];
         end
         if (int'(win_idx) == WIN_GLOB) rdata[31] = cfg_cam_ip_en_i;
      end else begin
         case (cfg_addr_i)
            ADDR_SHADOW_CTRL: begin
               rdata[SC_COMMIT] = pending_q;
               rdata[SC_BYPASS] = bypass_q;
            end
            ADDR_IRQ_EN:     rdata[IRQ_NUM_EV-1:0] = irq_en;
            ADDR_IRQ_STATUS: rdata[IRQ_NUM_EV-1:0] = irq_status;
            default: ;
         endcase
      end
   end

   // ---------------- outputs ----------------
   assign cfg_data_o           = rdata;
   assign cfg_ready_o          = 1'b1;
   assign cfg_rx_startaddr_o   = saddr_q;
   assign cfg_rx_size_o        = size_q;
   assign cfg_rx_datasize_o    = dsize_q;
   assign cfg_rx_continuous_o  = cont_q;
   assign cfg_rx_filter_o      = filt_q;
   assign cfg_rx_en_o          = en_p_q;
   assign cfg_rx_clr_o         = clr_p_q;
   assign cfg_cam_cfg_o        = active_q[WIN_GLOB];
   assign cfg_cam_cfg_ll_o     = active_q[WIN_LL];
   assign cfg_cam_cfg_ur_o     = active_q[WIN_UR];
   assign cfg_cam_cfg_size_o   = active_q[WIN_SIZE];
   assign cfg_cam_cfg_filter_o = active_q[WIN_FILTER];
   assign cfg_update_o         = update_q;

endmodule
